// File: rtl/chaos_pkg.sv
// chaos_pkg: shared types and constants for the chaos stream cipher.
// Holds the controller state encoding, the generator resync length and
// the key-field width used when slicing generator codes into key bytes.
package chaos_pkg;

  // Controller states; XFER is the only state in which data moves.
  typedef enum logic [1:0] {
    S_RESYNC  = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_XFER    = 2'd3
  } chaos_state_t;

  // Generator needs this many RESET cycles to return to idle from any point.
  localparam int CHAOS_RESYNC_CYCLES = 2;

  // Width of the field taken from each generator code.
  localparam int KEY_FIELD_W = 8;

  // Data word width of the cipher stream.
  localparam int DATA_W = 32;

  // Generator initial condition (1.0f) after its RESET.
  localparam logic [31:0] CHAOS_INIT = 32'h3f800000;

endpackage

// File: rtl/chaos_key_extract.sv
// chaos_key_extract: slices an 8-bit mantissa field starting at KEY_LSB
// out of each of the four generator codes and packs them into one key
// word, X in the most significant byte and W in the least significant.
module chaos_key_extract
  import chaos_pkg::*;
#(
  parameter int KEY_LSB = 8
) (
  input  logic [31:0]       i_x,
  input  logic [31:0]       i_y,
  input  logic [31:0]       i_z,
  input  logic [31:0]       i_w,
  output logic [DATA_W-1:0] o_key
);

  logic [KEY_FIELD_W-1:0] w_fx;
  logic [KEY_FIELD_W-1:0] w_fy;
  logic [KEY_FIELD_W-1:0] w_fz;
  logic [KEY_FIELD_W-1:0] w_fw;

  assign w_fx  = i_x[KEY_LSB +: KEY_FIELD_W];
  assign w_fy  = i_y[KEY_LSB +: KEY_FIELD_W];
  assign w_fz  = i_z[KEY_LSB +: KEY_FIELD_W];
  assign w_fw  = i_w[KEY_LSB +: KEY_FIELD_W];

  assign o_key = {w_fx, w_fy, w_fz, w_fw};

endmodule

// File: rtl/chaos_stream_cipher.sv
// chaos_stream_cipher: consumer of the chaos code generator.
// Sequences the generator STEP/RESET handshake, captures a key word from
// the codes on DONE and XORs it onto a valid/ready 32-bit stream. The same
// block encrypts and decrypts; two instances restarted together agree.
// Optional build macro CHAOS_KEY_ROTATE_EN: rotate the key left by one
// byte after every accepted word within a key period.
module chaos_stream_cipher
  import chaos_pkg::*;
#(
  parameter int KEY_LSB       = 8,
  parameter int WORDS_PER_KEY = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              CHAOS_STEP,
  output logic              CHAOS_RESET,
  input  logic              CHAOS_DONE,
  input  logic [31:0]       CHAOS_X,
  input  logic [31:0]       CHAOS_Y,
  input  logic [31:0]       CHAOS_Z,
  input  logic [31:0]       CHAOS_W,
  output logic              BUSY
);

  localparam logic [1:0] RESYNC_LAST = 2'(CHAOS_RESYNC_CYCLES - 1);
  localparam logic [7:0] WORD_LAST   = 8'(WORDS_PER_KEY - 1);

`ifdef CHAOS_KEY_ROTATE_EN
  // Byte-wise left rotation used to vary the key across one key period.
  function automatic logic [DATA_W-1:0] rotl8(input logic [DATA_W-1:0] k);
    return {k[DATA_W-9:0], k[DATA_W-1:DATA_W-8]};
  endfunction
`endif

  chaos_state_t      r_state;
  logic [1:0]        r_resync_cnt;
  logic [7:0]        r_word_cnt;
  logic [DATA_W-1:0] r_key;
  logic [DATA_W-1:0] r_data_p1;
  logic              r_vld_p1;

  logic [DATA_W-1:0] w_key_cap;
  logic              w_xfer;
  logic              w_in_hs;
  logic              w_key_last;
  logic              w_capture;

  chaos_key_extract #(
    .KEY_LSB (KEY_LSB)
  ) u_key_extract (
    .i_x   (CHAOS_X),
    .i_y   (CHAOS_Y),
    .i_z   (CHAOS_Z),
    .i_w   (CHAOS_W),
    .o_key (w_key_cap)
  );

  assign w_xfer     = (r_state == S_XFER);
  assign IN_READY   = w_xfer & (~r_vld_p1 | OUT_READY);
  assign w_in_hs    = IN_VALID & IN_READY;
  assign w_key_last = w_in_hs & (r_word_cnt == WORD_LAST);
  // A restart wins over a code set arriving in the same cycle.
  assign w_capture  = (r_state == S_REQ) & CHAOS_DONE & ~START;

  assign CHAOS_STEP  = (r_state == S_REQ);
  assign CHAOS_RESET = (r_state == S_RESYNC);
  assign BUSY        = ~w_xfer;
  assign OUT_VALID   = r_vld_p1;
  assign OUT_DATA    = r_data_p1;

  // Controller: resync the generator, request a code set, release it, then stream.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_RESYNC;
      r_resync_cnt <= '0;
      r_word_cnt   <= '0;
    end else if (START) begin
      r_state      <= S_RESYNC;
      r_resync_cnt <= '0;
      r_word_cnt   <= '0;
    end else begin
      case (r_state)
        S_RESYNC: begin
          if (r_resync_cnt == RESYNC_LAST) begin
            r_resync_cnt <= '0;
            r_state      <= S_REQ;
          end else begin
            r_resync_cnt <= r_resync_cnt + 2'd1;
          end
        end
        S_REQ: begin
          if (CHAOS_DONE) begin
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_state <= S_XFER;
        end
        S_XFER: begin
          if (w_key_last) begin
            r_word_cnt <= '0;
            r_state    <= S_REQ;
          end else if (w_in_hs) begin
            r_word_cnt <= r_word_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_RESYNC;
        end
      endcase
    end
  end

  // Key register: loaded unrotated from the codes on DONE; START leaves it intact.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_key <= '0;
    end else if (w_capture) begin
      r_key <= w_key_cap;
`ifdef CHAOS_KEY_ROTATE_EN
    end else if (w_in_hs) begin
      r_key <= rotl8(r_key);
`endif
    end
  end

  // ---- stage p0 -> p1: XOR input word with key into the output register ----
  // Output register: load on input handshake, otherwise drain on OUT_READY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else if (w_in_hs) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= IN_DATA ^ r_key;
    end else if (OUT_READY) begin
      r_vld_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chaos_stream_cipher.sv
// tb_chaos_stream_cipher: scoreboard bench for chaos_stream_cipher with two
// generator stubs. Instance 0 (WORDS_PER_KEY=3) carries the main stream,
// instance 1 (WORDS_PER_KEY=2) decrypts a ciphertext word produced by the
// same startup key.
module tb_chaos_stream_cipher;
  import chaos_pkg::*;

  localparam int STUB_LAT = 45;

`ifdef CHAOS_KEY_ROTATE_EN
  localparam logic [31:0] E_D2 = 32'hBBCCDDAA;
  localparam logic [31:0] E_W2 = 32'hBBCCDDAA;
  localparam logic [31:0] E_W3 = 32'h33225544;
  localparam logic [31:0] E_A  = 32'h8796E1B4;
  localparam logic [31:0] E_B  = 32'h691E4B78;
`else
  localparam logic [31:0] E_D2 = 32'hAABBCCDD;
  localparam logic [31:0] E_W2 = 32'hAABBCCDD;
  localparam logic [31:0] E_W3 = 32'h55443322;
  localparam logic [31:0] E_A  = 32'hB48796E1;
  localparam logic [31:0] E_B  = 32'h4B78691E;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic        d_start, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [31:0] d_in_data, d_out_data;

  logic [1:0]  g_step, g_rst;
  logic [1:0]  g_done = 2'b00;
  logic [31:0] g_x[2];
  logic [31:0] g_y[2];
  logic [31:0] g_z[2];
  logic [31:0] g_w[2];
  int          g_cnt[2];
  int          g_idx[2];

  logic [31:0] q[$];
  logic [31:0] dq[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  chaos_stream_cipher #(.KEY_LSB(8), .WORDS_PER_KEY(3)) dut (
    .CLK(clk), .RESET(rst), .START(start),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .CHAOS_STEP(g_step[0]), .CHAOS_RESET(g_rst[0]), .CHAOS_DONE(g_done[0]),
    .CHAOS_X(g_x[0]), .CHAOS_Y(g_y[0]), .CHAOS_Z(g_z[0]), .CHAOS_W(g_w[0]),
    .BUSY(busy)
  );

  chaos_stream_cipher #(.KEY_LSB(8), .WORDS_PER_KEY(2)) dec (
    .CLK(clk), .RESET(rst), .START(d_start),
    .IN_VALID(d_in_valid), .IN_READY(d_in_ready), .IN_DATA(d_in_data),
    .OUT_VALID(d_out_valid), .OUT_READY(d_out_ready), .OUT_DATA(d_out_data),
    .CHAOS_STEP(g_step[1]), .CHAOS_RESET(g_rst[1]), .CHAOS_DONE(g_done[1]),
    .CHAOS_X(g_x[1]), .CHAOS_Y(g_y[1]), .CHAOS_Z(g_z[1]), .CHAOS_W(g_w[1]),
    .BUSY(d_busy)
  );

  // Stub code sets: byte lane of key word placed in mantissa bits [15:8].
  function automatic logic [31:0] code(input int set, input int lane);
    logic [31:0] k;
    logic [7:0]  b;
    k = (set == 0) ? 32'hAABBCCDD : (set == 1) ? 32'h11223344 : 32'h55667788;
    b = k[31 - 8*lane -: 8];
    return {16'h0000, b, 8'h00};
  endfunction

  // Generator stubs: DONE after STUB_LAT STEP cycles, codes advance per iteration.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (g_rst[g]) begin
        g_cnt[g]  <= 0;
        g_idx[g]  <= 0;
        g_done[g] <= 1'b0;
        g_x[g]    <= CHAOS_INIT;
        g_y[g]    <= CHAOS_INIT;
        g_z[g]    <= CHAOS_INIT;
        g_w[g]    <= CHAOS_INIT;
      end else if (g_step[g] && !g_done[g]) begin
        if (g_cnt[g] == STUB_LAT - 1) begin
          g_done[g] <= 1'b1;
          g_cnt[g]  <= 0;
          g_x[g]    <= code(g_idx[g], 0);
          g_y[g]    <= code(g_idx[g], 1);
          g_z[g]    <= code(g_idx[g], 2);
          g_w[g]    <= code(g_idx[g], 3);
          g_idx[g]  <= (g_idx[g] + 1) % 3;
        end else begin
          g_cnt[g] <= g_cnt[g] + 1;
        end
      end else if (!g_step[g]) begin
        g_done[g] <= 1'b0;
        g_cnt[g]  <= 0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Monitor for the main instance output.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut_out unexpected word actual=%h required=none", out_data);
      end else begin
        check("dut_out", out_data, q.pop_front());
      end
    end
  end

  // Monitor for the decrypting instance output.
  always @(negedge clk) begin
    if (d_out_valid && d_out_ready) begin
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dec_out unexpected word actual=%h required=none", d_out_data);
      end else begin
        check("dec_out", d_out_data, dq.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 200) begin
      n++;
      tick();
    end
    if (!in_ready) begin
      check("send_timeout", 32'(n), 32'd0);
    end else begin
      q.push_back(e);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic dsend(input logic [31:0] d, input logic [31:0] e);
    int n;
    n = 0;
    d_in_valid = 1'b1;
    d_in_data  = d;
    #1;
    while (!d_in_ready && n < 200) begin
      n++;
      tick();
    end
    if (!d_in_ready) begin
      check("dsend_timeout", 32'(n), 32'd0);
    end else begin
      dq.push_back(e);
      tick();
    end
    d_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    d_start = 1'b0; d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check1("rst_step", g_step[0], 1'b0);
    check1("rst_chaos_reset", g_rst[0], 1'b1);
    check1("rst_busy", busy, 1'b1);
    check1("rst_in_ready", in_ready, 1'b0);

    // Startup handshake
    rst = 1'b0;
    n = 0;
    while (g_rst[0] && n < 10) begin n++; tick(); end
    check("resync_cycles", 32'(n), 32'd2);
    check1("step_after_resync", g_step[0], 1'b1);
    n = 0;
    while (!g_done[0] && n < 200) begin n++; tick(); end
    check("step_cycles_to_done", 32'(n), 32'(STUB_LAT));
    check1("step_at_done", g_step[0], 1'b1);
    tick();
    check1("release_step", g_step[0], 1'b0);
    check1("release_busy", busy, 1'b1);
    check1("release_in_ready", in_ready, 1'b0);
    tick();
    check1("xfer_step", g_step[0], 1'b0);
    check1("xfer_busy", busy, 1'b0);
    check1("xfer_in_ready", in_ready, 1'b1);

    // Decryption through the second instance with the same startup key
    dsend(32'hB88F9AA5, 32'h12345678);
    dsend(32'h00000000, E_D2);

    // Data XOR, three back-to-back words in one key period
    send(32'h12345678, 32'hB88F9AA5);
    check1("lat1_valid", out_valid, 1'b1);
    check("lat1_data", out_data, 32'hB88F9AA5);
    send(32'h00000000, E_W2);
    send(32'hFFFFFFFF, E_W3);
    check1("after_key_in_ready", in_ready, 1'b0);
    check1("after_key_busy", busy, 1'b1);
    check1("after_key_step", g_step[0], 1'b1);

    // Fourth word uses the next code set
    send(32'h12345678, 32'h0316653C);

    // Backpressure: held word stays stable, input blocked
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5A5A5;
    #1;
    for (int i = 0; i < 3; i++) begin
      check1("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, 32'h0316653C);
      check1("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    send(32'hA5A5A5A5, E_A);
    check1("nobubble_valid", out_valid, 1'b1);
    check("nobubble_data", out_data, E_A);
    send(32'h5A5A5A5A, E_B);

    // START while requesting: pending word held, generator resynced
    out_ready = 1'b0;
    repeat (10) tick();
    check1("req_step", g_step[0], 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("start_step_drop", g_step[0], 1'b0);
    check1("start_chaos_reset", g_rst[0], 1'b1);
    n = 0;
    while (g_rst[0] && n < 10) begin n++; tick(); end
    check("start_resync_cycles", 32'(n), 32'd2);
    check1("start_step_rise", g_step[0], 1'b1);
    check1("pending_valid", out_valid, 1'b1);
    check("pending_data", out_data, E_B);
    out_ready = 1'b1;
    send(32'h12345678, 32'hB88F9AA5);

    n = 0;
    while ((q.size() != 0 || dq.size() != 0) && n < 20) begin n++; tick(); end
    check("dut_queue_drained", 32'(q.size()), 32'd0);
    check("dec_queue_drained", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chaos_stream_cipher.md
Name: chaos_stream_cipher

Overview:
- Consumer side of the chaos code generator.
- Drives the generator's STEP/RESET handshake and captures CODE_X/Y/Z/W on DONE.
- Derives a 32-bit key word from the codes and XORs it onto a valid/ready 32-bit data stream.
- Encryption and decryption are the same operation: two instances restarted together stay in lockstep.

Parameters:
- KEY_LSB, 8: lowest mantissa bit of the 8-bit field taken from each code (legal 0..15).
- WORDS_PER_KEY, 1: data words processed per generator iteration (1..255).

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset (clock CLK)
- START  in  1  pulse; restart keystream from generator initial condition
- IN_VALID  in  1  input word valid
- IN_READY  out  1  input word accepted when IN_VALID & IN_READY
- IN_DATA  in  32  plaintext/ciphertext word
- OUT_VALID  out  1  output word valid
- OUT_READY  in  1  downstream accepts
- OUT_DATA  out  32  IN_DATA XOR key
- CHAOS_STEP  out  1  to generator STEP
- CHAOS_RESET  out  1  to generator RESET
- CHAOS_DONE  in  1  from generator DONE
- CHAOS_X, CHAOS_Y, CHAOS_Z, CHAOS_W  in  32 each  generator codes (IEEE-754 single)
- BUSY  out  1  high whenever state != XFER

Behaviour:
- Reset values: OUT_VALID 0, OUT_DATA 0, CHAOS_STEP 0, CHAOS_RESET 1, key 0, word_cnt 0, state RESYNC.
- States:
  - RESYNC:
    - Drive CHAOS_RESET=1, CHAOS_STEP=0 for exactly 2 cycles; the generator needs 2 cycles to return its counter to the idle value from any mid-iteration point.
    - Then go to REQ.
  - REQ:
    - Drive CHAOS_STEP=1 and wait for CHAOS_DONE=1.
    - In the cycle DONE is seen, the codes are already updated. Register key = {X[KEY_LSB+7:KEY_LSB], Y[..], Z[..], W[..]}, with X in the MSByte.
    - Go to RELEASE.
  - RELEASE:
    - Drive CHAOS_STEP=0 for 1 cycle; the generator clears its counter and DONE.
    - Go to XFER.
  - XFER:
    - IN_READY = !OUT_VALID | OUT_READY.
    - On an input handshake: OUT_DATA <= IN_DATA ^ key, OUT_VALID <= 1, word_cnt++.
    - When word_cnt reaches WORDS_PER_KEY on a handshake: word_cnt <= 0 and go to REQ in the same edge.
- IN_READY is 0 in every state except XFER.
- Latency: 1 cycle from input handshake to OUT_VALID.
  - Full throughput within a key.
  - Stall of ≥ generator iteration latency + 2 cycles between keys.
- Output register:
  - OUT_VALID clears on OUT_READY when there is no simultaneous input handshake.
  - A simultaneous input handshake and output handshake reloads the register (no bubble).
- START in any state:
  - Go to RESYNC next cycle and clear word_cnt; key is not cleared.
  - The held OUT_VALID/OUT_DATA word is preserved until consumed.
  - An input handshake in the same cycle as START is still processed with the old key.
- RESET has priority over START.
- CHAOS_DONE outside REQ is ignored.
- CHAOS_STEP never rises in the cycle directly after RELEASE ends without passing through REQ.

Optional Feature:
- Macro: CHAOS_KEY_ROTATE_EN.
- Defined:
  - After each input handshake within a key, key <= {key[23:0], key[31:24]} (rotate left 8).
  - On capture, key is loaded unrotated.
- Undefined: key is constant for all WORDS_PER_KEY words.

Decomposition:
- Package chaos_pkg:
  - State enum (RESYNC, REQ, RELEASE, XFER).
  - CHAOS_RESYNC_CYCLES = 2.
  - KEY_FIELD_W = 8.
  - CHAOS_INIT = 32'h3f800000 (bench reference).
- Sub-module chaos_key_extract: combinational field extraction and concatenation of the 4 codes into the 32-bit key, parameterised by KEY_LSB.
- FSM, counters and the datapath register stay in the top.

Test Plan:
- Startup handshake: bench generator stub returns X=0x0000AA00, Y=0x0000BB00, Z=0x0000CC00, W=0x0000DD00 with DONE after 45 STEP cycles.
  - CHAOS_RESET high 2 cycles after RESET release.
  - Then STEP high until DONE, then STEP low exactly 1 cycle.
  - Key = 0xAABBCCDD.
- Data XOR: with key 0xAABBCCDD, IN_DATA 0x12345678 → OUT_DATA 0xB88F9AA5 one cycle after handshake.
  - Same word back through a second instance → 0x12345678.
- WORDS_PER_KEY=3: 3 back-to-back words accepted, then IN_READY=0, then STEP rises.
  - Fourth word uses the next stub code set.
- Backpressure: OUT_READY=0 holds OUT_VALID/OUT_DATA stable and IN_READY=0.
  - OUT_READY=1 with IN_VALID=1 gives a new word each cycle with no bubble.
- START mid-REQ: STEP drops the next cycle, CHAOS_RESET is high 2 cycles, then the first key equals the startup key.
  - Pending output word is delivered unchanged.
- CHAOS_KEY_ROTATE_EN, WORDS_PER_KEY=2, key 0xAABBCCDD, inputs 0,0 → outputs 0xAABBCCDD then 0xBBCCDDAA.
